// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Cleans up a raw mechanical push-button level. The asynchronous input is
//   first brought into the CLOCK domain through a two-flop synchronizer. A
//   four-state FSM then accepts a new level only after the synchronized value
//   has held that level for STABLE_CYCLES consecutive cycles. A glitch that
//   returns to the old level before then is rejected silently.
//
//   For a clean step, Debounced changes at rising edge STABLE_CYCLES + 3.
//   Edge 1 is the first edge that samples the new level. Two edges are spent
//   in the synchronizer, one edge enters the check state, and STABLE_CYCLES
//   edges are spent counting.
//
// Parameters:
//   STABLE_CYCLES - cycles (N) a new level must persist; 1 .. 2**CNT_WIDTH-1
//   CNT_WIDTH     - width of the stability counter
//
// Ports:
//   CLOCK     in   sole clock, rising-edge active
//   Reset     in   synchronous, active-low reset
//   NoisyIn   in   raw, asynchronous, bouncing button level
//   Debounced out  registered debounced level
//   RiseEdge  out  registered one-cycle pulse on a Debounced 0 -> 1 change
//   FallEdge  out  registered one-cycle pulse on a Debounced 1 -> 0 change
//   Busy      out  registered; 1 while a level change is being qualified
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic NoisyIn,
    output logic Debounced,
    output logic RiseEdge,
    output logic FallEdge,
    output logic Busy
);

    // The encoding is chosen so that bit 1 is the debounced level and bit 0
    // is the busy flag. The output decode below stays explicit so that the
    // intent reads from the state names.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } state_t;

    // A qualification ends on the cycle in which the counter already holds
    // N-1. The counter therefore never needs to represent N, and it cannot
    // wrap.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                 sync0_q,     sync0_d;
    logic                 sync1_q,     sync1_d;
    state_t               state_q,     state_d;
    logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
    logic                 debounced_q, debounced_d;
    logic                 rise_q,      rise_d;
    logic                 fall_q,      fall_d;
    logic                 busy_q,      busy_d;

    // The FSM samples only the synchronizer output.
    logic s;
    assign s = sync1_q;

    // -------------------------------------------------------------------------
    // Synchronizer next state
    // -------------------------------------------------------------------------
    always_comb begin
        sync0_d = NoisyIn;
        sync1_d = sync0_q;
    end

    // -------------------------------------------------------------------------
    // FSM next state and counter
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end

            CHECK_HIGH: begin
                if (!s) begin
                    // Glitch rejected: return to the old level without a pulse.
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            STABLE_HIGH: begin
                if (!s) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end

            CHECK_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs, decoded from the next state so that they line up
    // with the state register (no extra cycle of latency).
    // -------------------------------------------------------------------------
    always_comb begin
        debounced_d = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
        busy_d      = (state_d == CHECK_HIGH)  || (state_d == CHECK_LOW);
        // Pulses come only from completed qualifications. Aborted ones move
        // CHECK_* back to the same stable level, so they never match here.
        rise_d      = (state_q == CHECK_HIGH) && (state_d == STABLE_HIGH);
        fall_d      = (state_q == CHECK_LOW)  && (state_d == STABLE_LOW);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        // NOTE: reset is synchronous and takes priority over every next-state
        // term. It lives only here, so the combinational logic stays
        // reset-free. Asserting reset while high clears Debounced directly,
        // without going through CHECK_LOW, so no FallEdge is produced.
        if (!Reset) begin
            sync0_q     <= 1'b0;
            sync1_q     <= 1'b0;
            state_q     <= STABLE_LOW;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, whatever order the statements are in.
            sync0_q     <= sync0_d;
            sync1_q     <= sync1_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
        end
    end

    assign Debounced = debounced_q;
    assign RiseEdge  = rise_q;
    assign FallEdge  = fall_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Scoreboard bench for button_debouncer with N = 4.
//
// The driver applies one (NoisyIn, Reset) pair per cycle. For each pair it
// asks a behavioural model what the outputs must be after the next rising
// edge, and pushes that answer into a queue. A separate monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
//
// The model is written in run-length terms:
//   - The FSM sees NoisyIn delayed by two edges.
//   - The accepted level flips once N+1 consecutive samples disagree with it.
//   - Busy means a disagreeing run is in progress.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int N = 4;
    localparam int W = 20;

    logic CLOCK   = 1'b0;
    logic Reset   = 1'b0;
    logic NoisyIn = 1'b0;
    logic Debounced, RiseEdge, FallEdge, Busy;

    always #5 CLOCK = ~CLOCK;

    button_debouncer #(
        .STABLE_CYCLES(N),
        .CNT_WIDTH    (W)
    ) dut (
        .CLOCK    (CLOCK),
        .Reset    (Reset),
        .NoisyIn  (NoisyIn),
        .Debounced(Debounced),
        .RiseEdge (RiseEdge),
        .FallEdge (FallEdge),
        .Busy     (Busy)
    );

    typedef struct packed {
        logic deb;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // -------------------------------------------------------------------------
    // Reference model state
    // -------------------------------------------------------------------------
    logic dly[2];        // inputs still on their way to the FSM
    int   run_len;       // consecutive samples that disagree with the level
    logic level;         // accepted level
    int   edge_no = 0;

    function automatic exp_t model_step(input logic noisy, input logic rst_n);
        exp_t e;
        logic seen;
        e = '0;
        if (!rst_n) begin
            dly[0]  = 1'b0;
            dly[1]  = 1'b0;
            run_len = 0;
            level   = 1'b0;
        end else begin
            seen   = dly[1];
            dly[1] = dly[0];
            dly[0] = noisy;
            if (seen != level) begin
                run_len++;
                if (run_len == N + 1) begin
                    level   = seen;
                    run_len = 0;
                    e.rise  = seen;
                    e.fall  = !seen;
                end
            end else begin
                run_len = 0;
            end
        end
        e.deb  = level;
        e.busy = (run_len > 0);
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s edge=%0d t=%0t actual=%b required=%b",
                     name, edge_no, $time, act, req);
        end
    endtask

    // Monitor: one expected record per rising edge, sampled after the edge.
    always @(posedge CLOCK) begin
        exp_t e;
        #1;
        edge_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("debounced", Debounced, e.deb);
            check("rise_edge", RiseEdge,  e.rise);
            check("fall_edge", FallEdge,  e.fall);
            check("busy",      Busy,      e.busy);
        end
    end

    // Rule check independent of the model: the two pulses are never
    // active together.
    always @(negedge CLOCK) begin
        if (Reset && (RiseEdge === 1'b1) && (FallEdge === 1'b1)) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_pulses t=%0t actual=11 required=not both",
                     $time);
        end
    end

    // -------------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------------
    task automatic drive(input logic noisy, input logic rst_n);
        @(negedge CLOCK);
        NoisyIn = noisy;
        Reset   = rst_n;
        exp_q.push_back(model_step(noisy, rst_n));
        @(posedge CLOCK);
    endtask

    task automatic hold(input logic noisy, input int cycles);
        for (int i = 0; i < cycles; i++) drive(noisy, 1'b1);
    endtask

    initial begin
        dly[0]  = 1'b0;
        dly[1]  = 1'b0;
        run_len = 0;
        level   = 1'b0;

        // Reset for 3 cycles, then idle low: all outputs stay 0.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
        hold(1'b0, 20);

        // Clean rising step, then a clean falling step.
        hold(1'b1, 12);
        hold(1'b0, 12);

        // Short high pulse: Busy only, no level change.
        hold(1'b1, 3);
        hold(1'b0, 12);

        // Bounce 1,0,1,0 at 2 cycles each, then a steady high.
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 12);

        // 2-cycle low glitch while high: rejected.
        hold(1'b0, 2);
        hold(1'b1, 12);

        // Reset for 1 cycle while high: no FallEdge, then requalify.
        drive(1'b1, 1'b0);
        hold(1'b1, 12);

        // Clean fall from high to finish the directed part.
        hold(1'b0, 12);

        // Randomized bouncing segments with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                drive(1'($urandom_range(0, 1)), 1'b0);
            end
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, N + 4)));
        end
        hold(1'b0, 12);

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge CLOCK);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
